blitter_mem_arbiter: RTL
========================

Name: blitter_mem_arbiter

Overview:
- Merges the blitter's two memory channels onto one SDRAM controller client port.
  - Write channel: single-word writes from the blitter write FIFO.
  - Read channel: line fills for the blitter source cache.
- Sits between the blitter and the SDRAM arbiter/controller.
- One transaction outstanding at a time.
- Reads normally win; writes are protected against starvation and against read-after-write hazards on the same line.

Parameters:
- BURST_WORDS, 4: 32-bit words per read line fill. Power of two, minimum 2.
- STARVE_LIMIT, 8: number of consecutive read grants allowed while a write is pending before the write is forced. Range 1..255.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- blitw_request  in  1  write FIFO head valid; held until blitw_ack
- blitw_address  in  26  byte address, word aligned
- blitw_wdata  in  32  write data
- blitw_byte_en  in  4  byte lane enables
- blitw_ack  out  1  write accepted; 1-cycle pulse
- blitr_request  in  1  cache line-fill request; held until blitr_ack
- blitr_address  in  26  line fill byte address
- blitr_rdata  out  32  fill data word
- blitr_valid  out  1  blitr_rdata valid this cycle
- blitr_ack  out  1  read accepted by memory; 1-cycle pulse
- blitr_complete  out  1  last fill word; coincides with the final blitr_valid
- mem_request  out  1  transaction request to controller
- mem_write  out  1  1 = write, 0 = burst read
- mem_address  out  26  transaction address
- mem_wdata  out  32  write data
- mem_byte_en  out  4  write lane enables; 0000 on reads
- mem_ack  in  1  controller accepted the request
- mem_rdata  in  32  read data
- mem_rdata_valid  in  1  read data word valid

Behaviour:
- Reset (sync, active-high, clock = clock):
  - state = IDLE.
  - mem_request, mem_write, blitw_ack, blitr_ack, blitr_valid, blitr_complete = 0.
  - mem_address, mem_wdata, mem_byte_en = 0.
  - starve_cnt = 0, word_cnt = 0.
  - Reset during any state abandons the transaction; the controller shares the same reset.
- States: IDLE, WRITE, READ_REQ, READ_DATA.
- IDLE, grant decision at cycle T:
  - Only blitw_request: grant write.
  - Only blitr_request: grant read.
  - Both pending:
    - Hazard (blitw_address[25:L] == blitr_address[25:L], L = log2(BURST_WORDS)+2): grant write.
    - Else starve_cnt == STARVE_LIMIT: grant write.
    - Else: grant read.
- starve_cnt:
  - Increments (saturating) on a read grant while blitw_request = 1.
  - Clears on a write grant, or in any IDLE cycle with blitw_request = 0.
- Write grant:
  - mem_write = 1; mem_address, mem_wdata, mem_byte_en registered from the blitw_* inputs.
  - mem_request = 1 from T+1; state = WRITE.
- Read grant:
  - mem_write = 0; mem_address = {blitr_address[25:2], 2'b00}; mem_byte_en = 0000.
  - mem_request = 1 from T+1; state = READ_REQ.
- WRITE:
  - mem_request held until the cycle mem_ack = 1.
  - blitw_ack = mem_ack in that cycle (combinational).
  - Next cycle: mem_request = 0, state = IDLE.
- READ_REQ:
  - On mem_ack: blitr_ack = 1 (same cycle); mem_request = 0 next cycle; word_cnt = 0; state = READ_DATA.
- READ_DATA:
  - Each cycle with mem_rdata_valid: blitr_valid = 1 and blitr_rdata = mem_rdata (combinational passthrough); word_cnt increments.
  - When word_cnt == BURST_WORDS-1 and mem_rdata_valid: blitr_complete = 1 in the same cycle, then state = IDLE.
  - Gaps between valid words are allowed.
- Ignored inputs:
  - mem_rdata_valid outside READ_DATA: blitr_valid stays 0.
  - mem_ack in IDLE or READ_DATA.
- Turnaround:
  - At least one IDLE cycle between transactions.
  - Minimum write cost is 3 cycles (grant, request+ack, return to IDLE).
- Requesters must hold address and data stable until their ack.
  - A request dropped before ack while not yet granted is simply not granted.
  - A request dropped after grant does not cancel the transaction.
- Hazard check covers the write FIFO head only. Deeper ordering is the cache's responsibility (flush on BLIT_SET_SRC_ADDR).

Test Plan:
- Lone write 0x0000104, data 0xAABBCCDD, byte_en 0010; controller acks 2 cycles after mem_request -> mem_write = 1 with identical fields; blitw_ack pulses exactly once, in the ack cycle; IDLE after.
- Lone read 0x0002000, BURST_WORDS = 4; controller returns words 1,2,3,4 with one gap cycle after word 2 -> blitr_ack once; four blitr_valid pulses; blitr_complete only with word 4.
- Both requests continuously, different lines, STARVE_LIMIT = 8 -> grant order is 8 reads, 1 write, repeating; starve_cnt returns to 0 after each write.
- Both requests, write 0x0002008 and read 0x0002000 (same 16-byte line) -> write granted first, read granted in the following IDLE.
- Spurious mem_rdata_valid during IDLE and WRITE -> no blitr_valid and no blitr_complete.
- Reset asserted mid-READ_DATA after 2 words -> next cycle all outputs 0 and state IDLE; a new read after reset completes with all 4 words.

Source files
------------

// File: rtl/blitter_mem_arbiter.sv
// rtl/blitter_mem_arbiter.sv - merges blitter write and line-fill read channels onto one SDRAM client port
module blitter_mem_arbiter #(
    parameter int BURST_WORDS  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        blitw_request,
    input  logic [25:0] blitw_address,
    input  logic [31:0] blitw_wdata,
    input  logic [3:0]  blitw_byte_en,
    output logic        blitw_ack,
    input  logic        blitr_request,
    input  logic [25:0] blitr_address,
    output logic [31:0] blitr_rdata,
    output logic        blitr_valid,
    output logic        blitr_ack,
    output logic        blitr_complete,
    output logic        mem_request,
    output logic        mem_write,
    output logic [25:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_en,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rdata_valid
);
    localparam int LINE_LSB = $clog2(BURST_WORDS) + 2;
    localparam int WCW      = $clog2(BURST_WORDS);

    typedef enum logic [1:0] {IDLE, WRITE, READ_REQ, READ_DATA} state_t;

    state_t         state;
    logic [7:0]     starve_cnt;
    logic [WCW-1:0] word_cnt;
    logic           hazard;
    logic           grant_write;
    logic           grant_read;
    logic           last_word;

    // A read of the line the pending write touches would fetch stale data, so the write goes first.
    assign hazard      = blitw_address[25:LINE_LSB] == blitr_address[25:LINE_LSB];
    assign grant_write = blitw_request &&
                         (!blitr_request || hazard || starve_cnt == 8'(STARVE_LIMIT));
    assign grant_read  = blitr_request && !grant_write;
    assign last_word   = word_cnt == WCW'(BURST_WORDS - 1);

    assign blitw_ack      = (state == WRITE) && mem_ack;
    assign blitr_ack      = (state == READ_REQ) && mem_ack;
    assign blitr_valid    = (state == READ_DATA) && mem_rdata_valid;
    assign blitr_complete = blitr_valid && last_word;
    assign blitr_rdata    = mem_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            mem_request <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_byte_en <= '0;
            starve_cnt  <= '0;
            word_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!blitw_request) begin
                        starve_cnt <= '0;
                    end
                    if (grant_write) begin
                        state       <= WRITE;
                        mem_request <= 1'b1;
                        mem_write   <= 1'b1;
                        mem_address <= blitw_address;
                        mem_wdata   <= blitw_wdata;
                        mem_byte_en <= blitw_byte_en;
                        starve_cnt  <= '0;
                    end else if (grant_read) begin
                        state       <= READ_REQ;
                        mem_request <= 1'b1;
                        mem_write   <= 1'b0;
                        mem_address <= blitr_address & ~26'h3;
                        mem_byte_en <= 4'b0000;
                        if (blitw_request && starve_cnt != 8'hFF) begin
                            starve_cnt <= starve_cnt + 8'd1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_request <= 1'b0;
                        state       <= IDLE;
                    end
                end
                READ_REQ: begin
                    if (mem_ack) begin
                        mem_request <= 1'b0;
                        word_cnt    <= '0;
                        state       <= READ_DATA;
                    end
                end
                READ_DATA: begin
                    if (mem_rdata_valid) begin
                        word_cnt <= word_cnt + WCW'(1);
                        if (last_word) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
